// File: rtl/mano_alu_seq.sv
//------------------------------------------------------------------------------
// mano_alu_seq : owns Mano AC/E and sequences one ALU micro-op per clock.
// Optional shadow ALU cross-check enabled by defining MANO_SEQ_FAULTCHK_EN.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mano_alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic [1:0]  mop,
  input  logic [11:0] rr,
  input  logic [15:0] dr,
  output logic        busy,
  output logic        done,
  output logic [15:0] ac,
  output logic        e,
  output logic        skip,
  output logic        halt,
  output logic        fault,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_e_in,
  output logic [3:0]  alu_func,
  input  logic [15:0] alu_z,
  input  logic        alu_e_out
);

  localparam int DATAWIDTH = 16;
  localparam int FUNCWIDTH = 4;

  localparam logic [FUNCWIDTH-1:0] NO_FUNC     = 4'd0;
  localparam logic [FUNCWIDTH-1:0] ADD_FUNC    = 4'd1;
  localparam logic [FUNCWIDTH-1:0] AND_FUNC    = 4'd2;
  localparam logic [FUNCWIDTH-1:0] PASSDR_FUNC = 4'd3;
  localparam logic [FUNCWIDTH-1:0] CMA_FUNC    = 4'd4;
  localparam logic [FUNCWIDTH-1:0] CME_FUNC    = 4'd5;
  localparam logic [FUNCWIDTH-1:0] CIR_FUNC    = 4'd6;
  localparam logic [FUNCWIDTH-1:0] CIL_FUNC    = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic                 mode_q;
  logic [1:0]           mop_q;
  logic [11:0]          mask_q;
  logic [DATAWIDTH-1:0] dr_q;
  logic [DATAWIDTH-1:0] ac_q;
  logic                 e_q;
  logic                 skip_q;
  logic                 halt_q;
  logic                 busy_q;
  logic                 done_q;

  logic [3:0]           w_sel_idx;
  logic                 w_sel_vld;
  logic [11:0]          w_mask_rest;

  logic [FUNCWIDTH-1:0] w_func;
  logic [DATAWIDTH-1:0] w_a;
  logic                 w_ac_wr;
  logic                 w_e_wr;
  logic                 w_ac_chk;
  logic                 w_e_chk;
  logic [DATAWIDTH-1:0] w_ac_val;
  logic                 w_e_val;
  logic                 w_skip_set;
  logic                 w_halt_set;

  // Highest set bit of the pending mask is the next register-ref step.
  always_comb begin
    w_sel_idx = 4'd0;
    w_sel_vld = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (mask_q[i]) begin
        w_sel_idx = 4'(i);
        w_sel_vld = 1'b1;
      end
    end
    w_mask_rest = w_sel_vld ? (mask_q & ~(12'b1 << w_sel_idx)) : 12'd0;
  end

  always_comb begin
    w_func     = NO_FUNC;
    w_a        = dr_q;
    w_ac_wr    = 1'b0;
    w_e_wr     = 1'b0;
    w_ac_chk   = 1'b0;
    w_e_chk    = 1'b0;
    w_ac_val   = alu_z;
    w_e_val    = alu_e_out;
    w_skip_set = 1'b0;
    w_halt_set = 1'b0;
    if (state_q == S_EXEC) begin
      if (!mode_q) begin
        case (mop_q)
          2'b00:   begin w_func = AND_FUNC;    w_ac_wr = 1'b1; end
          2'b01:   begin w_func = ADD_FUNC;    w_ac_wr = 1'b1; w_e_wr = 1'b1; end
          2'b10:   begin w_func = PASSDR_FUNC; w_ac_wr = 1'b1; end
          default: w_func = NO_FUNC;
        endcase
        w_ac_chk = w_ac_wr;
        w_e_chk  = w_e_wr;
      end else if (w_sel_vld) begin
        case (w_sel_idx)
          4'd11: begin w_ac_wr = 1'b1; w_ac_val = '0; end
          4'd10: begin w_e_wr = 1'b1; w_e_val = 1'b0; end
          4'd9:  begin w_func = CMA_FUNC; w_ac_wr = 1'b1; w_ac_chk = 1'b1; end
          4'd8:  begin w_func = CME_FUNC; w_e_wr = 1'b1; w_e_chk = 1'b1; end
          4'd7:  begin
            w_func = CIR_FUNC; w_ac_wr = 1'b1; w_e_wr = 1'b1;
            w_ac_chk = 1'b1; w_e_chk = 1'b1;
          end
          4'd6:  begin
            w_func = CIL_FUNC; w_ac_wr = 1'b1; w_e_wr = 1'b1;
            w_ac_chk = 1'b1; w_e_chk = 1'b1;
          end
          // INC reuses the adder but leaves E alone so FFFF wraps to 0000.
          4'd5:  begin
            w_func = ADD_FUNC; w_a = 16'h0001; w_ac_wr = 1'b1; w_ac_chk = 1'b1;
          end
          4'd4:    w_skip_set = ~ac_q[DATAWIDTH-1];
          4'd3:    w_skip_set = ac_q[DATAWIDTH-1];
          4'd2:    w_skip_set = (ac_q == '0);
          4'd1:    w_skip_set = ~e_q;
          4'd0:    w_halt_set = 1'b1;
          default: w_func = NO_FUNC;
        endcase
      end
    end
  end

  assign alu_func = w_func;
  assign alu_a    = w_a;
  assign alu_b    = ac_q;
  assign alu_e_in = e_q;

`ifdef MANO_SEQ_FAULTCHK_EN
  logic                 fault_q;
  logic [DATAWIDTH-1:0] w_sh_z;
  logic                 w_sh_e;
  logic                 w_fault_set;

  always_comb begin
    w_sh_z = '0;
    w_sh_e = e_q;
    case (w_func)
      ADD_FUNC:    {w_sh_e, w_sh_z} = {1'b0, w_a} + {1'b0, ac_q};
      AND_FUNC:    w_sh_z = w_a & ac_q;
      PASSDR_FUNC: w_sh_z = w_a;
      CMA_FUNC:    w_sh_z = ~ac_q;
      CME_FUNC:    w_sh_e = ~e_q;
      CIR_FUNC:    begin w_sh_z = {e_q, ac_q[DATAWIDTH-1:1]}; w_sh_e = ac_q[0]; end
      CIL_FUNC:    begin w_sh_z = {ac_q[DATAWIDTH-2:0], e_q}; w_sh_e = ac_q[DATAWIDTH-1]; end
      default:     w_sh_z = '0;
    endcase
    w_fault_set = (w_ac_chk && (alu_z != w_sh_z)) || (w_e_chk && (alu_e_out != w_sh_e));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fault_q <= 1'b0;
    else if (w_fault_set)
      fault_q <= 1'b1;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      mop_q   <= 2'b00;
      mask_q  <= '0;
      dr_q    <= '0;
      ac_q    <= '0;
      e_q     <= 1'b0;
      skip_q  <= 1'b0;
      halt_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start && !halt_q) begin
            mode_q  <= mode;
            mop_q   <= mop;
            mask_q  <= rr;
            dr_q    <= dr;
            skip_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_ac_wr)    ac_q   <= w_ac_val;
          if (w_e_wr)     e_q    <= w_e_val;
          if (w_skip_set) skip_q <= 1'b1;
          if (w_halt_set) halt_q <= 1'b1;
          mask_q <= w_mask_rest;
          if (!mode_q || (w_mask_rest == '0)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ac   = ac_q;
  assign e    = e_q;
  assign skip = skip_q;
  assign halt = halt_q;

endmodule

`default_nettype wire

// File: tb/tb_mano_alu_seq.sv
// Directed bench for mano_alu_seq with a behavioural combinational ALU.
`default_nettype none

module tb_mano_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  mop = 2'b00;
  logic [11:0] rr = '0;
  logic [15:0] dr = '0;
  logic        busy, done, e, skip, halt, fault, alu_e_in, alu_e_out;
  logic [15:0] ac, alu_a, alu_b, alu_z;
  logic [3:0]  alu_func;
  logic        flip = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  mano_alu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .mop(mop), .rr(rr), .dr(dr),
    .busy(busy), .done(done), .ac(ac), .e(e), .skip(skip), .halt(halt), .fault(fault),
    .alu_a(alu_a), .alu_b(alu_b), .alu_e_in(alu_e_in), .alu_func(alu_func),
    .alu_z(alu_z), .alu_e_out(alu_e_out)
  );

  always #5 clk = ~clk;

  // ALU: 0 NO, 1 ADD, 2 AND, 3 PASSDR, 4 CMA, 5 CME, 6 CIR, 7 CIL
  always_comb begin
    alu_z     = 16'h0000;
    alu_e_out = alu_e_in;
    case (alu_func)
      4'd1: {alu_e_out, alu_z} = {1'b0, alu_a} + {1'b0, alu_b};
      4'd2: alu_z = alu_a & alu_b;
      4'd3: alu_z = alu_a;
      4'd4: alu_z = ~alu_b;
      4'd5: alu_e_out = ~alu_e_in;
      4'd6: begin alu_z = {alu_e_in, alu_b[15:1]}; alu_e_out = alu_b[0]; end
      4'd7: begin alu_z = {alu_b[14:0], alu_e_in}; alu_e_out = alu_b[15]; end
      default: alu_z = 16'h0000;
    endcase
    if (flip && alu_func == 4'd1) alu_z[0] = ~alu_z[0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic m, input logic [1:0] op,
                     input logic [11:0] r, input logic [15:0] d, input int exp_cyc);
    int cyc;
    @(negedge clk);
    mode = m; mop = op; rr = r; dr = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; mode = ~m; mop = ~op; rr = ~r; dr = 16'hDEAD;
    @(negedge clk);
    cyc = 1;
    chk({tag, "_busy"}, busy, 1);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_cyc);
    chk({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    logic seen_busy, seen_done;
    logic exp_fault;
`ifdef MANO_SEQ_FAULTCHK_EN
    exp_fault = 1'b1;
`else
    exp_fault = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ac", ac, 0);
    chk("rst_flags", {busy, done, e, skip, halt, fault}, 0);
    chk("idle_func", alu_func, 0);
    rst_n = 1'b1;

    run("lda_f0", 0, 2'b10, 12'h000, 16'h00F0, 2);
    chk("lda_f0_ac", ac, 16'h00F0);
    run("and", 0, 2'b00, 12'h000, 16'h0FF0, 2);
    chk("and_ac", ac, 16'h00F0);
    run("add", 0, 2'b01, 12'h000, 16'hFF20, 2);
    chk("add_ac_e", {e, ac}, {1'b1, 16'h0010});

    run("lda_8001", 0, 2'b10, 12'h000, 16'h8001, 2);
    run("cle", 1, 2'b00, 12'h400, 16'h0000, 2);
    chk("cle_e", e, 0);
    run("cil", 1, 2'b00, 12'h040, 16'h0000, 2);
    chk("cil_ac_e", {e, ac}, {1'b1, 16'h0002});

    run("lda_1234", 0, 2'b10, 12'h000, 16'h1234, 2);
    chk("pre_multi", {e, ac}, {1'b1, 16'h1234});
    run("multi", 1, 2'b00, 12'hE24, 16'h0000, 6);
    chk("multi_ac_e_skip", {skip, e, ac}, {1'b1, 1'b0, 16'h0000});

    run("rsvd", 0, 2'b11, 12'h000, 16'h5555, 2);
    chk("rsvd_skip_clr_ac", {skip, ac}, {1'b0, 16'h0000});
    run("zero_mask", 1, 2'b00, 12'h000, 16'h0000, 2);
    chk("zero_mask_state", {skip, e, ac}, 0);

    run("lda_0003", 0, 2'b10, 12'h000, 16'h0003, 2);
    run("cir", 1, 2'b00, 12'h080, 16'h0000, 2);
    chk("cir_ac_e", {e, ac}, {1'b1, 16'h0001});
    run("cme_spa", 1, 2'b00, 12'h110, 16'h0000, 3);
    chk("cme_spa_e_skip", {e, skip}, {1'b0, 1'b1});
    run("lda_8000", 0, 2'b10, 12'h000, 16'h8000, 2);
    run("sna_sze", 1, 2'b00, 12'h00A, 16'h0000, 3);
    chk("sna_skip", skip, 1);
    run("cma_sza", 1, 2'b00, 12'h204, 16'h0000, 3);
    chk("cma_sza", {skip, ac}, {1'b0, 16'h7FFF});

    run("hlt_sze", 1, 2'b00, 12'h003, 16'h0000, 3);
    chk("hlt_sze_flags", {halt, skip}, 2'b11);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; mop = 2'b10; dr = 16'h1111;
    @(posedge clk);
    #1 start = 1'b0;
    seen_busy = 1'b0; seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_busy |= busy;
      seen_done |= done;
    end
    chk("halted_ignore", {seen_busy, seen_done}, 0);
    chk("halted_ac", ac, 16'h7FFF);
    rst_n = 1'b0;
    #1 chk("rst_clr_halt", {halt, ac}, 0);
    @(negedge clk) rst_n = 1'b1;

    // reset during the second EXEC cycle of a four-step mask
    @(negedge clk);
    mode = 1'b1; rr = 12'h324; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ac", ac, 0);
    chk("mid_rst_flags", {busy, done, e, skip, halt, fault}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_quiet", {busy, done}, 0);
    run("post_lda", 0, 2'b10, 12'h000, 16'h0042, 2);
    chk("post_lda_ac", ac, 16'h0042);

    chk("pre_fault", fault, 0);
    flip = 1'b1;
    run("fault_add", 0, 2'b01, 12'h000, 16'h0001, 2);
    flip = 1'b0;
    chk("fault_ac", ac, 16'h0042);
    chk("fault_set", fault, exp_fault);
    run("after_fault", 0, 2'b10, 12'h000, 16'h0007, 2);
    chk("fault_sticky", fault, exp_fault);
    chk("after_fault_ac", ac, 16'h0007);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
